ars_request_queue: RTL and testbench
====================================

# ars_request_queue

Buffered front end for the 8-bit combinational arithmetic right shifter. It accepts shift requests (operand plus shift amount) over a valid/ready handshake and holds them in a small FIFO. It presents the head request to an internal `Arithmetic_right_shift` instance and registers the shifted result into a valid/ready output stage. This decouples the bursty request producer from the result consumer and puts a register boundary after the shifter.

## Interface
- `DEPTH`, 4: request FIFO entries; power of two, at least 2.
- `DATA_W`, 8: operand and result width; fixed to 8 to match the shifter.
- `SHIFT_W`, 4: shift-amount width.
- `clk` input, 1: single clock; all state updates on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `flush` input, 1: synchronous clear of the FIFO and output stage.
- `in_valid` input, 1: request present.
- `in_ready` output, 1: FIFO can accept a request.
- `A_in` input, DATA_W: signed operand.
- `Shift_value_in` input, SHIFT_W: shift amount, 0 to 15.
- `out_valid` output, 1: `Result` holds a valid result.
- `out_ready` input, 1: consumer accepts the result.
- `Result` output, DATA_W: registered arithmetic-right-shift result.
- `Result_shift` output, SHIFT_W: shift amount that produced `Result`.
- `count` output, $clog2(DEPTH)+1: FIFO occupancy, excluding the output stage.

## Operation
- Push when `in_valid && in_ready`. `{A_in, Shift_value_in}` is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- `in_ready = (count != DEPTH)`, computed from registered state only; there is no combinational path from `out_ready`.
- Load condition: the output stage loads when FIFO is non-empty and (`!out_valid || out_ready`).
  - On load: `Result` and `Result_shift` take the shifter output for the FIFO head, `rd_ptr` increments modulo DEPTH, and `out_valid` goes to 1.
- `out_valid` clears when `out_valid && out_ready` and no load occurs in the same cycle.
- Push and pop in the same cycle leave `count` unchanged; push when full is impossible because `in_ready` is low.
- Shift rules:
  - Result bit 7 is always replicated.
  - `Shift_value` 0 passes the operand through unchanged.
  - `Shift_value` 8 to 15 saturates to all sign bits (0x00 or 0xFF).
- `flush` takes priority over push and load that cycle:
  - pointers and `count` return to 0;
  - `out_valid` returns to 0;
  - `Result` and `Result_shift` hold their values.
- Two-state view of the output stage:
  - EMPTY (`out_valid`=0) goes to FULL on load.
  - FULL goes to EMPTY when `out_ready` is high and the FIFO is empty.
  - FULL stays FULL on hold, or on drain plus reload.

## Timing
- Reset values (`rst_n` low, asynchronous):
  - `out_valid`=0, `Result`=0, `Result_shift`=0, `count`=0;
  - `in_ready`=1 once the pointers are cleared;
  - FIFO storage is not reset.
- Latency: a request accepted at edge N into an empty queue with the output stage EMPTY appears at `out_valid`=1 after edge N+1. Minimum latency is 2 edges from presentation to result.
- Throughput: one request per cycle sustained when `out_ready` is held high.
- Back-pressure: with `out_ready` low, the FIFO fills. `in_ready` falls in the cycle after the DEPTH-th push. The total held is DEPTH+1 requests (FIFO plus output register).
- Pointer wrap: `wr_ptr` and `rd_ptr` wrap independently. Full and empty are resolved by `count`, not by pointer equality.
- Reset asserted mid-burst drops all queued and in-flight requests immediately. No partial result is emitted after reset deassertion.

## Structure
- A shared package `ars_pkg` holds:
  - `ARS_DATA_W`=8 and `ARS_SHIFT_W`=4;
  - the request struct type `{A, Shift_value}`.
- One sub-module: `ars_req_fifo`, the DEPTH-entry pointer FIFO with `count`.
- The top instantiates `ars_req_fifo` and `Arithmetic_right_shift` and owns the output register.

## Test plan
- Single request, shift 2, operand 0x33 -> `Result`=0x0C, `Result_shift`=2, `out_valid` asserted 2 edges after presentation.
- Back-to-back burst with `out_ready`=1:
  - requests: 0xF0 shift 3, 0x80 shift 7, 0xAA shift 0, 0x01 shift 1;
  - required results in order: 0xFE, 0xFF, 0xAA, 0x00;
  - one result per cycle.
- Saturation:
  - 0x3C shift 8 -> 0x00;
  - 0x80 shift 15 -> 0xFF;
  - 0xFF shift 1 -> 0xFF.
- Back-pressure and wrap:
  - hold `out_ready`=0 and push 0x10 to 0x14, each with shift 1;
  - `in_ready` drops after 5 accepted requests (count=4 plus the output register);
  - release `out_ready` and push 6 more;
  - results emerge in FIFO order with no loss or duplication across the pointer wrap.
- Flush with count=3 and `out_valid`=1:
  - after the edge: count=0, `out_valid`=0, `in_ready`=1;
  - the next request, 0xC0 shift 2, yields 0xF0.
- Async reset pulse mid-stream with a request queued:
  - outputs go to reset values without waiting for a clock edge;
  - no stale result appears after release.

Source files
------------

// File: rtl/ars_pkg.sv
// ---------------------------------------------------------------------------
// ars_pkg
// Shared definitions for the arithmetic-right-shift request queue.
//   ARS_DATA_W  : operand / result width (the shifter is fixed at 8 bits)
//   ARS_SHIFT_W : shift-amount width
//   ars_req_t   : one queued request {A, Shift_value}
//   out_state_e : two-state view of the registered output stage
// ---------------------------------------------------------------------------
package ars_pkg;

    localparam int ARS_DATA_W  = 8;
    localparam int ARS_SHIFT_W = 4;

    typedef struct packed {
        logic [ARS_DATA_W-1:0]  A;
        logic [ARS_SHIFT_W-1:0] Shift_value;
    } ars_req_t;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/Arithmetic_right_shift.sv
// ---------------------------------------------------------------------------
// Arithmetic_right_shift
// Combinational 8-bit arithmetic right shifter.
//   A           : signed operand
//   Shift_value : shift amount 0..15
//   Result      : A shifted right with bit 7 replicated into the vacated bits
// ---------------------------------------------------------------------------
module Arithmetic_right_shift
    import ars_pkg::*;
(
    input  logic [ARS_DATA_W-1:0]  A,
    input  logic [ARS_SHIFT_W-1:0] Shift_value,
    output logic [ARS_DATA_W-1:0]  Result
);

    // Any amount of 8 or more leaves nothing but copies of the sign bit, so
    // the top shift bit selects saturation directly and only the low three
    // bits drive the barrel shift.
    always_comb begin
        Result = A;
        if (Shift_value[3]) begin
            Result = {ARS_DATA_W{A[ARS_DATA_W-1]}};
        end else begin
            Result = $signed(A) >>> Shift_value[2:0];
        end
    end

endmodule

// File: rtl/ars_req_fifo.sv
// ---------------------------------------------------------------------------
// ars_req_fifo
// DEPTH-entry pointer FIFO of shift requests with an occupancy counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : synchronous clear of pointers and count (wins over push/pop)
//   push_i     : write wrData_i at the write pointer (ignored when full)
//   pop_i      : advance the read pointer (ignored when empty)
//   wrData_i   : request to store
//   rdData_o   : request at the head of the FIFO
//   count_o    : number of stored requests
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
// ---------------------------------------------------------------------------
module ars_req_fifo
    import ars_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  ars_req_t         wrData_i,
    output ars_req_t         rdData_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    ars_req_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign rdData_o = mem_q[rdPtr_q];

    // Guard the requests against the occupancy so a misbehaving caller can
    // never corrupt the counter. Pointers wrap on their own because DEPTH is
    // a power of two; full and empty come from the count, not pointer equality.
    always_comb begin
        doPush  = push_i && !full_o;
        doPop   = pop_i && !empty_o;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (doPush && !flush_i) begin
            mem_q[wrPtr_q] <= wrData_i;
        end
    end

endmodule

// File: rtl/ars_request_queue.sv
// ---------------------------------------------------------------------------
// ars_request_queue
// Buffered valid/ready front end for the 8-bit arithmetic right shifter.
// Requests are queued in ars_req_fifo, the head is shifted combinationally
// and the result is captured into a registered valid/ready output stage.
//   clk, rst_n     : clock, asynchronous active-low reset
//   flush          : synchronous clear of FIFO and output valid
//   in_valid       : request present
//   in_ready       : FIFO has room (from registered count only)
//   A_in           : signed operand
//   Shift_value_in : shift amount 0..15
//   out_valid      : Result / Result_shift hold a valid result
//   out_ready      : consumer takes the result
//   Result         : registered shift result
//   Result_shift   : shift amount that produced Result
//   count          : FIFO occupancy, not counting the output register
// ---------------------------------------------------------------------------
module ars_request_queue
    import ars_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = ARS_DATA_W,
    parameter int SHIFT_W = ARS_SHIFT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        A_in,
    input  logic [SHIFT_W-1:0]       Shift_value_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        Result,
    output logic [SHIFT_W-1:0]       Result_shift,
    output logic [$clog2(DEPTH):0]   count
);

    ars_req_t           wrReq;
    ars_req_t           headReq;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               push;
    logic               load;
    logic [DATA_W-1:0]  shiftResult;
    out_state_e         outState_q;
    logic [DATA_W-1:0]  result_q;
    logic [SHIFT_W-1:0] resultShift_q;

    assign wrReq.A           = A_in;
    assign wrReq.Shift_value = Shift_value_in;

    assign in_ready = !fifoFull;
    assign push     = in_valid && in_ready;

    // The output register refills whenever it is empty or being drained this
    // cycle, which gives one result per cycle with out_ready held high.
    assign load = !fifoEmpty && ((outState_q == OUT_EMPTY) || out_ready);

    ars_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush),
        .push_i   (push),
        .pop_i    (load),
        .wrData_i (wrReq),
        .rdData_o (headReq),
        .count_o  (count),
        .full_o   (fifoFull),
        .empty_o  (fifoEmpty)
    );

    Arithmetic_right_shift u_shift (
        .A           (headReq.A),
        .Shift_value (headReq.Shift_value),
        .Result      (shiftResult)
    );

    // Output stage: EMPTY loads to FULL; FULL stays FULL on hold or on a
    // drain with reload, and returns to EMPTY on a drain with nothing behind
    // it. Flush drops the valid flag but leaves the last data in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outState_q    <= OUT_EMPTY;
            result_q      <= '0;
            resultShift_q <= '0;
        end else if (flush) begin
            outState_q    <= OUT_EMPTY;
        end else if (load) begin
            outState_q    <= OUT_FULL;
            result_q      <= shiftResult;
            resultShift_q <= headReq.Shift_value;
        end else if (out_ready) begin
            outState_q    <= OUT_EMPTY;
        end
    end

    assign out_valid    = (outState_q == OUT_FULL);
    assign Result       = result_q;
    assign Result_shift = resultShift_q;

endmodule

// File: tb/tb_ars_request_queue.sv
// ---------------------------------------------------------------------------
// tb_ars_request_queue
// Directed-vector bench with a scoreboard: each accepted request pushes its
// hand-computed result onto expQ, and a monitor pops and compares on every
// output handshake.
// ---------------------------------------------------------------------------
module tb_ars_request_queue;

    typedef struct packed {
        logic [7:0] res;
        logic [3:0] sh;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A_in;
    logic [3:0] Shift_value_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Result;
    logic [3:0] Result_shift;
    logic [2:0] count;

    exp_t expQ[$];
    int   checks;
    int   errors;

    ars_request_queue #(
        .DEPTH   (4),
        .DATA_W  (8),
        .SHIFT_W (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .A_in           (A_in),
        .Shift_value_in (Shift_value_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .Result         (Result),
        .Result_shift   (Result_shift),
        .count          (count)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch with both values.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one request as soon as in_ready allows, hold it across one edge,
    // and record its expected result. Inputs change 1 time unit after posedge.
    task automatic applyStimulus(input logic [7:0] a, input logic [3:0] s, input logic [7:0] expRes);
        int waited;
        exp_t e;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout: got 0x0, expected 0x1");
        end else begin
            in_valid       = 1'b1;
            A_in           = a;
            Shift_value_in = s;
            e.res          = expRes;
            e.sh           = s;
            expQ.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    // Let the output side empty the scoreboard, bounded by a cycle budget.
    task automatic waitDrain(input string name);
        int waited;
        waited = 0;
        while (expQ.size() != 0 && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain: got %0d pending, expected 0 pending", name, expQ.size());
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: a handshake seen at the falling edge completes at the next
    // rising edge, so compare it against the oldest expected result here.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got 0x%0h, expected no output", Result);
            end else begin
                e = expQ.pop_front();
                checkOutput("result", {24'd0, Result}, {24'd0, e.res});
                checkOutput("result_shift", {28'd0, Result_shift}, {28'd0, e.sh});
            end
        end
    end

    // Main directed sequence.
    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        flush          = 1'b0;
        in_valid       = 1'b0;
        A_in           = '0;
        Shift_value_in = '0;
        out_ready      = 1'b0;

        // Reset values
        #2;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_result", {24'd0, Result}, 32'd0);
        checkOutput("reset_result_shift", {28'd0, Result_shift}, 32'd0);
        checkOutput("reset_count", {29'd0, count}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request and two-edge latency
        out_ready = 1'b1;
        applyStimulus(8'h33, 4'd2, 8'h0C);
        checkOutput("lat_not_yet_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("lat_result", {24'd0, Result}, 32'h0C);
        checkOutput("lat_result_shift", {28'd0, Result_shift}, 32'd2);

        // Back-to-back burst, one result per cycle
        applyStimulus(8'hF0, 4'd3, 8'hFE);
        applyStimulus(8'h80, 4'd7, 8'hFF);
        applyStimulus(8'hAA, 4'd0, 8'hAA);
        applyStimulus(8'h01, 4'd1, 8'h00);
        checkOutput("burst_valid_a", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("burst_valid_b", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("burst_idle", {31'd0, out_valid}, 32'd0);
        waitDrain("burst");

        // Saturation and sign fill
        applyStimulus(8'h3C, 4'd8, 8'h00);
        applyStimulus(8'h80, 4'd15, 8'hFF);
        applyStimulus(8'hFF, 4'd1, 8'hFF);
        waitDrain("saturate");

        // Back-pressure fills FIFO plus output register, then wrap
        out_ready = 1'b0;
        applyStimulus(8'h10, 4'd1, 8'h08);
        applyStimulus(8'h11, 4'd1, 8'h08);
        applyStimulus(8'h12, 4'd1, 8'h09);
        applyStimulus(8'h13, 4'd1, 8'h09);
        applyStimulus(8'h14, 4'd1, 8'h0A);
        checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_count", {29'd0, count}, 32'd4);
        checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        applyStimulus(8'h15, 4'd1, 8'h0A);
        applyStimulus(8'h16, 4'd1, 8'h0B);
        applyStimulus(8'h17, 4'd1, 8'h0B);
        applyStimulus(8'h18, 4'd1, 8'h0C);
        applyStimulus(8'h19, 4'd1, 8'h0C);
        applyStimulus(8'h1A, 4'd1, 8'h0D);
        waitDrain("wrap");

        // Flush with three queued and one held in the output register
        out_ready = 1'b0;
        applyStimulus(8'h20, 4'd0, 8'h20);
        applyStimulus(8'h21, 4'd0, 8'h21);
        applyStimulus(8'h22, 4'd0, 8'h22);
        applyStimulus(8'h23, 4'd0, 8'h23);
        checkOutput("pre_flush_count", {29'd0, count}, 32'd3);
        checkOutput("pre_flush_valid", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        expQ.delete();
        checkOutput("flush_count", {29'd0, count}, 32'd0);
        checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("flush_result_hold", {24'd0, Result}, 32'h20);
        out_ready = 1'b1;
        applyStimulus(8'hC0, 4'd2, 8'hF0);
        waitDrain("post_flush");

        // Asynchronous reset mid-stream with a request queued
        out_ready = 1'b0;
        applyStimulus(8'h55, 4'd1, 8'h2A);
        applyStimulus(8'h66, 4'd2, 8'h19);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("async_rst_result", {24'd0, Result}, 32'd0);
        checkOutput("async_rst_result_shift", {28'd0, Result_shift}, 32'd0);
        checkOutput("async_rst_count", {29'd0, count}, 32'd0);
        checkOutput("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        expQ.delete();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("post_rst_no_output", {31'd0, out_valid}, 32'd0);
        end
        applyStimulus(8'h90, 4'd4, 8'hF9);
        waitDrain("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
